// File: rtl/spc7110_muldiv_seq.sv
// SPC7110-style byte-addressed multiply/divide unit: 16x16 shift-add multiply with
// optional accumulate, 32/16 restoring divide, both sequential with optional latency padding.
module spc7110_muldiv_seq #(
    parameter int MUL_PAD = 0,
    parameter int DIV_PAD = 0,
    parameter int MAC_EN  = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       alu_sfc_enable,
    input  logic [3:0] sfc_alu_port,
    input  logic       sfc_rd,
    input  logic       sfc_wr,
    input  logic [7:0] sfc_data_in,
    output logic [7:0] sfc_data_out
);

    localparam int PAD_MAX = (MUL_PAD > DIV_PAD) ? MUL_PAD : DIV_PAD;
    localparam int CNT_W   = ($clog2(PAD_MAX + 1) > 5) ? $clog2(PAD_MAX + 1) : 5;
    localparam logic [CNT_W-1:0] MUL_PAD_C = CNT_W'(MUL_PAD);
    localparam logic [CNT_W-1:0] DIV_PAD_C = CNT_W'(DIV_PAD);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_PAD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a, r;
    logic [15:0]      mb, db, m;
    logic             dz, sgn_mode, acc, busy, is_div;

    // working datapath registers
    logic [31:0] mcand, prod, quo;
    logic [15:0] mplier, rem, dvsr, dz_m;
    logic        neg_q, neg_r, dz_pend;

    logic        wr_en, rd_en, mul_trig, div_trig, mode_wr;
    logic [15:0] mb_next, db_next;
    logic        mul_a_neg, mul_b_neg, div_a_neg, div_b_neg;
    logic [15:0] mul_a_mag, mul_b_mag, div_b_mag;
    logic [31:0] div_a_mag;
    logic [16:0] rem_sh, rem_diff;
    logic        fits;
    logic [31:0] mul_res, div_q;
    logic [15:0] div_r;
    logic [CNT_W-1:0] pad_len;
    logic [7:0]  rd_byte;

    assign wr_en    = alu_sfc_enable & sfc_wr;
    assign rd_en    = alu_sfc_enable & sfc_rd;
    assign mul_trig = wr_en & (sfc_alu_port == 4'h5);
    assign div_trig = wr_en & (sfc_alu_port == 4'h7);
    assign mode_wr  = wr_en & (sfc_alu_port == 4'hE);

    // Operands include the high byte being written on the trigger cycle.
    assign mb_next   = {sfc_data_in, mb[7:0]};
    assign db_next   = {sfc_data_in, db[7:0]};
    assign mul_a_neg = sgn_mode & a[15];
    assign mul_b_neg = sgn_mode & mb_next[15];
    assign div_a_neg = sgn_mode & a[31];
    assign div_b_neg = sgn_mode & db_next[15];
    assign mul_a_mag = mul_a_neg ? 16'(-a[15:0]) : a[15:0];
    assign mul_b_mag = mul_b_neg ? 16'(-mb_next) : mb_next;
    assign div_a_mag = div_a_neg ? 32'(-a) : a;
    assign div_b_mag = div_b_neg ? 16'(-db_next) : db_next;

    assign rem_sh   = {rem, quo[31]};
    assign rem_diff = rem_sh - {1'b0, dvsr};
    assign fits     = (rem_sh >= {1'b0, dvsr});

    assign mul_res = neg_q ? 32'(-prod) : prod;
    assign div_q   = neg_q ? 32'(-quo) : quo;
    assign div_r   = neg_r ? 16'(-rem) : rem;
    assign pad_len = is_div ? DIV_PAD_C : MUL_PAD_C;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_byte = 8'h00;
        case (sfc_alu_port)
            4'h0: rd_byte = a[7:0];
            4'h1: rd_byte = a[15:8];
            4'h2: rd_byte = a[23:16];
            4'h3: rd_byte = a[31:24];
            4'h4: rd_byte = mb[7:0];
            4'h5: rd_byte = mb[15:8];
            4'h6: rd_byte = db[7:0];
            4'h7: rd_byte = db[15:8];
            4'h8: rd_byte = r[7:0];
            4'h9: rd_byte = r[15:8];
            4'hA: rd_byte = r[23:16];
            4'hB: rd_byte = r[31:24];
            4'hC: rd_byte = m[7:0];
            4'hD: rd_byte = m[15:8];
            4'hE: rd_byte = {6'b0, acc, sgn_mode};
            default: rd_byte = {busy, dz, 6'b0};
        endcase
    end

    // NOTE: working registers are loaded on every trigger before they are consumed, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (mul_trig) begin
            mcand  <= {16'h0000, mul_a_mag};
            mplier <= mul_b_mag;
            prod   <= '0;
            neg_q  <= mul_a_neg ^ mul_b_neg;
        end else if (div_trig) begin
            quo     <= div_a_mag;
            rem     <= '0;
            dvsr    <= div_b_mag;
            neg_q   <= div_a_neg ^ div_b_neg;
            neg_r   <= div_a_neg;
            dz_pend <= (db_next == 16'h0000);
            dz_m    <= a[15:0];
        end else if (state == S_MUL) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (state == S_DIV) begin
            quo <= {quo[30:0], fits};
            rem <= fits ? rem_diff[15:0] : rem_sh[15:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            cnt          <= '0;
            a            <= '0;
            mb           <= '0;
            db           <= '0;
            r            <= '0;
            m            <= '0;
            dz           <= 1'b0;
            sgn_mode     <= 1'b0;
            acc          <= 1'b0;
            busy         <= 1'b0;
            is_div       <= 1'b0;
            sfc_data_out <= 8'h00;
        end else begin
            if (rd_en) sfc_data_out <= rd_byte;

            if (wr_en) begin
                case (sfc_alu_port)
                    4'h0: a[7:0]    <= sfc_data_in;
                    4'h1: a[15:8]   <= sfc_data_in;
                    4'h2: a[23:16]  <= sfc_data_in;
                    4'h3: a[31:24]  <= sfc_data_in;
                    4'h4: mb[7:0]   <= sfc_data_in;
                    4'h5: mb[15:8]  <= sfc_data_in;
                    4'h6: db[7:0]   <= sfc_data_in;
                    4'h7: db[15:8]  <= sfc_data_in;
                    default: ;
                endcase
            end

            // Mode writes and new triggers pre-empt whatever the sequencer was doing.
            if (mode_wr) begin
                sgn_mode <= sfc_data_in[0];
                acc      <= sfc_data_in[1] & (MAC_EN != 0);
                a        <= '0;
                mb       <= '0;
                db       <= '0;
                r        <= '0;
                m        <= '0;
                dz       <= 1'b0;
                busy     <= 1'b0;
                state    <= S_IDLE;
            end else if (mul_trig || div_trig) begin
                state  <= mul_trig ? S_MUL : S_DIV;
                cnt    <= '0;
                busy   <= 1'b1;
                is_div <= div_trig;
            end else begin
                case (state)
                    S_MUL: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(15)) state <= S_FIX;
                    end
                    S_DIV: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(31)) state <= S_FIX;
                    end
                    S_FIX: begin
                        if (is_div) begin
                            r  <= dz_pend ? 32'hFFFF_FFFF : div_q;
                            m  <= dz_pend ? dz_m : div_r;
                            dz <= dz_pend;
                        end else begin
                            r  <= acc ? r + mul_res : mul_res;
                            dz <= 1'b0;
                        end
                        if (pad_len == '0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_PAD;
                            cnt   <= pad_len - 1'b1;
                        end
                    end
                    S_PAD: begin
                        if (cnt == '0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spc7110_muldiv_seq.sv
// Scoreboard bench for spc7110_muldiv_seq: an arithmetic register-level model predicts every
// read byte; a monitor compares sfc_data_out after each read strobe.
module tb_spc7110_muldiv_seq;

    localparam int MUL_PAD = 3;
    localparam int DIV_PAD = 2;
    localparam int MAC_EN  = 1;

    logic       CLK;
    logic       RESET;
    logic       alu_sfc_enable;
    logic [3:0] sfc_alu_port;
    logic       sfc_rd;
    logic       sfc_wr;
    logic [7:0] sfc_data_in;
    logic [7:0] sfc_data_out;

    spc7110_muldiv_seq #(.MUL_PAD(MUL_PAD), .DIV_PAD(DIV_PAD), .MAC_EN(MAC_EN)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .alu_sfc_enable(alu_sfc_enable),
        .sfc_alu_port  (sfc_alu_port),
        .sfc_rd        (sfc_rd),
        .sfc_wr        (sfc_wr),
        .sfc_data_in   (sfc_data_in),
        .sfc_data_out  (sfc_data_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] port;
        logic [7:0] val;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: architectural registers plus the edge numbers of the pending commit.
    logic [31:0] m_a, m_r, s_a;
    logic [15:0] m_mb, m_db, m_m, s_b;
    bit          m_dz, m_sgn, m_acc, m_busy, m_pend, m_op_div;
    int          m_cyc = 0;
    int          commit_cyc, busy_end;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] view(input logic [3:0] p);
        case (p)
            4'h0: return m_a[7:0];
            4'h1: return m_a[15:8];
            4'h2: return m_a[23:16];
            4'h3: return m_a[31:24];
            4'h4: return m_mb[7:0];
            4'h5: return m_mb[15:8];
            4'h6: return m_db[7:0];
            4'h7: return m_db[15:8];
            4'h8: return m_r[7:0];
            4'h9: return m_r[15:8];
            4'hA: return m_r[23:16];
            4'hB: return m_r[31:24];
            4'hC: return m_m[7:0];
            4'hD: return m_m[15:8];
            4'hE: return {6'b0, m_acc, m_sgn};
            default: return {m_busy, m_dz, 6'b0};
        endcase
    endfunction

    task automatic model_clear();
        m_a = '0; m_r = '0; m_mb = '0; m_db = '0; m_m = '0;
        m_dz = 0; m_sgn = 0; m_acc = 0; m_busy = 0; m_pend = 0;
    endtask

    task automatic do_commit();
        longint x, y, q, rr;
        if (!m_op_div) begin
            x = m_sgn ? longint'($signed(s_a[15:0])) : longint'(s_a[15:0]);
            y = m_sgn ? longint'($signed(s_b)) : longint'(s_b);
            q = x * y;
            m_r = m_acc ? m_r + q[31:0] : q[31:0];
            m_dz = 0;
        end else if (s_b == 16'h0000) begin
            m_r = 32'hFFFF_FFFF;
            m_m = s_a[15:0];
            m_dz = 1;
        end else begin
            x = m_sgn ? longint'($signed(s_a)) : longint'(s_a);
            y = m_sgn ? longint'($signed(s_b)) : longint'(s_b);
            q = x / y;
            rr = x % y;
            m_r = q[31:0];
            m_m = rr[15:0];
            m_dz = 0;
        end
    endtask

    task automatic start_op(input bit is_div);
        s_a = m_a;
        s_b = is_div ? m_db : m_mb;
        m_op_div = is_div;
        m_pend = 1;
        m_busy = 1;
        commit_cyc = m_cyc + (is_div ? 33 : 17);
        busy_end = commit_cyc + (is_div ? DIV_PAD : MUL_PAD);
    endtask

    task automatic model_edge(input bit rst, en, rd, wr, input logic [3:0] p, input logic [7:0] d);
        bit trig;
        m_cyc++;
        if (rst) begin
            model_clear();
            return;
        end
        if (en && rd) exp_q.push_back('{p, view(p), m_cyc});
        trig = en && wr && (p == 4'h5 || p == 4'h7 || p == 4'hE);
        if (!trig) begin
            if (m_pend && m_cyc == commit_cyc) begin
                do_commit();
                m_pend = 0;
            end
            if (m_busy && m_cyc == busy_end) m_busy = 0;
        end
        if (en && wr) begin
            case (p)
                4'h0: m_a[7:0] = d;
                4'h1: m_a[15:8] = d;
                4'h2: m_a[23:16] = d;
                4'h3: m_a[31:24] = d;
                4'h4: m_mb[7:0] = d;
                4'h5: begin m_mb[15:8] = d; start_op(0); end
                4'h6: m_db[7:0] = d;
                4'h7: begin m_db[15:8] = d; start_op(1); end
                4'hE: begin
                    m_sgn = d[0];
                    m_acc = d[1] && (MAC_EN != 0);
                    m_a = '0; m_mb = '0; m_db = '0; m_r = '0; m_m = '0; m_dz = 0;
                    m_busy = 0;
                    m_pend = 0;
                end
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive on the falling edge, let the model see the rising edge.
    task automatic cyc(input bit rst, en, rd, wr, input logic [3:0] p, input logic [7:0] d);
        @(negedge CLK);
        RESET = rst; alu_sfc_enable = en; sfc_rd = rd; sfc_wr = wr;
        sfc_alu_port = p; sfc_data_in = d;
        @(posedge CLK);
        model_edge(rst, en, rd, wr, p, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'h0, 8'h00);
    endtask

    task automatic wr(input logic [3:0] p, input logic [7:0] d);
        cyc(0, 1, 0, 1, p, d);
    endtask

    task automatic rd(input logic [3:0] p);
        cyc(0, 1, 1, 0, p, 8'h00);
    endtask

    task automatic do_reset();
        cyc(1, 1, 1, 1, 4'h7, 8'h00);
        #1 check("reset_data_out", sfc_data_out, 8'h00);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) rd(4'(i));
    endtask

    task automatic poll(input int n);
        logic [3:0] pl [7];
        pl = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
        for (int i = 0; i < n; i++) rd(pl[i % 7]);
    endtask

    task automatic set_a(input logic [31:0] v);
        wr(4'h0, v[7:0]); wr(4'h1, v[15:8]); wr(4'h2, v[23:16]); wr(4'h3, v[31:24]);
    endtask

    task automatic mul(input logic [15:0] b);
        wr(4'h4, b[7:0]); wr(4'h5, b[15:8]);
    endtask

    task automatic div(input logic [15:0] b);
        wr(4'h6, b[7:0]); wr(4'h7, b[15:8]);
    endtask

    // Monitor: every read strobe accepted at a rising edge is compared at the next falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            if (!RESET && alu_sfc_enable && sfc_rd) begin
                @(negedge CLK);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: got %h expected no read", sfc_data_out);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_port%h_cyc%0d", e.port, e.cyc), sfc_data_out, e.val);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        tests++;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        RESET = 1'b1; alu_sfc_enable = 1'b0; sfc_rd = 1'b0; sfc_wr = 1'b0;
        sfc_alu_port = 4'h0; sfc_data_in = 8'h00;
        do_reset();
        read_all();

        // Unsigned multiply
        wr(4'hE, 8'h00); set_a(32'h0000_1234); mul(16'h5678); poll(24);
        // Signed multiply, then accumulate twice
        wr(4'hE, 8'h01); set_a(32'h0000_FFFE); mul(16'h0003); poll(24);
        wr(4'hE, 8'h03); set_a(32'h0000_0003); mul(16'h0004); poll(22);
        wr(4'h5, 8'h00); poll(22); rd(4'hE);
        // Divides: unsigned, signed, by zero, signed overflow
        wr(4'hE, 8'h00); set_a(32'h0001_0000); div(16'h0003); poll(40);
        wr(4'hE, 8'h01); set_a(32'hFFFF_FFF9); div(16'h0002); poll(40);
        wr(4'hE, 8'h00); set_a(32'h1234_5678); div(16'h0000); poll(40);
        wr(4'hE, 8'h01); set_a(32'h8000_0000); div(16'hFFFF); poll(40);
        // Abort by mode write at T+10
        wr(4'hE, 8'h00); set_a(32'h0000_1000); div(16'h0007); poll(9);
        wr(4'hE, 8'h00); poll(42);
        // Retrigger at T+5, with staging writes while busy
        set_a(32'h0000_ABCD); div(16'h0010); poll(4);
        wr(4'h7, 8'h01); set_a(32'h5555_AAAA); wr(4'h4, 8'h33); poll(40); read_all();
        // Read-only ports ignore writes; read and write in the same cycle
        for (int p = 8; p < 14; p++) wr(4'(p), 8'h5A);
        cyc(0, 1, 1, 1, 4'h2, 8'h77); rd(4'h2); read_all();
        // Reset at T+8 of a padded multiply
        wr(4'hE, 8'h02); set_a(32'h0000_7FFF); mul(16'h7FFF); idle(7);
        do_reset(); read_all(); poll(25);

        for (int i = 0; i < 500; i++) begin
            int kind;
            logic [3:0] p;
            p = 4'($urandom_range(0, 15));
            kind = $urandom_range(0, 9);
            if (p == 4'hE && kind >= 4 && $urandom_range(0, 3) != 0) p = 4'h5;
            cyc(0, $urandom_range(0, 9) != 0, kind < 5 || kind == 9, kind >= 4 && kind != 9,
                p, 8'($urandom));
        end
        poll(50);
        idle(2);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spc7110_muldiv_seq.md
SPC7110_MULDIV_SEQ -- requirements
Module: spc7110_muldiv_seq

Interface
REQ-001 Parameter MUL_PAD, default 0: extra wait cycles appended to every multiply, for hardware-accurate latency.
REQ-002 Parameter DIV_PAD, default 0: extra wait cycles appended to every divide.
REQ-003 Parameter MAC_EN, default 1: 1 enables accumulate mode; 0 forces mode bit1 to read and act as 0.
REQ-004 CLK  in  1  clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 alu_sfc_enable  in  1  qualifies rd/wr as ALU accesses.
REQ-007 sfc_alu_port  in  4  register address 0x0-0xF.
REQ-008 sfc_rd  in  1  read strobe, one-cycle.
REQ-009 sfc_wr  in  1  write strobe, one-cycle.
REQ-010 sfc_data_in  in  8  write data.
REQ-011 sfc_data_out  out  8  registered read data.

Function
REQ-012 Register map SHALL be: 0-3 A[31:0] (dividend; A[15:0] multiplicand); 4-5 MB[15:0] multiplier; 6-7 DB[15:0] divisor; 8-B R[31:0] result; C-D M[15:0] remainder; E mode; F status. All little-endian.
REQ-013 Ports 0-7 SHALL be read/write, ports 8-D read-only, and writes to them ignored.
REQ-014 A read of port p at edge T SHALL present that byte on sfc_data_out after edge T; sfc_data_out holds its value otherwise.
REQ-015 A write to port 5 SHALL trigger a multiply; a write to port 7 SHALL trigger a divide. Operands are snapshotted at the trigger edge, including the byte written that cycle.
REQ-016 Mode write (port E) SHALL set signed=d[0] and acc=d[1]&MAC_EN, zero A/MB/DB/R/M/DZ, and abort any operation (busy=0 next cycle). Reading port E returns {6'b0,acc,signed}.
REQ-017 Status (port F) SHALL read {busy,DZ,6'b0}.
REQ-018 FSM states SHALL be IDLE, MUL (16 cycles, radix-2 shift-add on magnitudes), DIV (32 cycles, restoring shift-subtract on magnitudes), FIX (1 cycle: sign correction, accumulate, commit), PAD (MUL_PAD or DIV_PAD cycles, skipped if 0), returning to IDLE.
REQ-019 Latency: with trigger at edge T, R/M/DZ SHALL update at edge T+17 (multiply) or T+33 (divide); busy=1 from after edge T until after edge T+L, where L=17+MUL_PAD or 33+DIV_PAD.
REQ-020 R, M and DZ SHALL change only at the commit edge, atomically; they hold their old values while busy.
REQ-021 Multiply: R = A[15:0]*MB as 32-bit, signed two's complement when signed=1; M unchanged; DZ cleared.
REQ-022 Accumulate: with acc=1, a multiply SHALL commit R = R_old + product mod 2^32; divides ignore acc.
REQ-023 Divide: R = A/DB truncated toward zero, M = remainder with the sign of the dividend (signed mode); unsigned otherwise. DZ cleared.
REQ-024 Divisor 0: R=0xFFFFFFFF, M=A[15:0], DZ=1, same latency.
REQ-025 Signed 0x80000000 / 0xFFFF: R=0x80000000, M=0 (wrap, no trap).
REQ-026 A trigger while busy SHALL abort the current operation and restart with the new operands; the aborted result is never committed; timing restarts from the new trigger edge.
REQ-027 Triggers of both kinds in one cycle are impossible (single port); a read and an unrelated write in the same cycle SHALL both take effect.
REQ-028 A write to A/MB/DB while busy SHALL update the staging register only and not affect the running operation.

Reset
REQ-029 RESET SHALL force IDLE, clear A, MB, DB, R, M, DZ, signed, acc and busy, and set sfc_data_out=0x00; it overrides a simultaneous access or an operation in progress.

Verification
REQ-030 Unsigned: A=0x1234, MB=0x5678 -> R=0x06260060 at T+17; status 0x80 before, 0x00 after.
REQ-031 Signed multiply (mode=1): A=0xFFFE, MB=0x0003 -> R=0xFFFFFFFA; mode=3, 3*4 twice -> R=0x00000018.
REQ-032 Divide: unsigned 0x00010000/0x0003 -> R=0x00005555, M=0x0001 at T+33; signed 0xFFFFFFF9/0x0002 -> R=0xFFFFFFFD, M=0xFFFF.
REQ-033 Divide by zero: A=0x12345678, DB=0 -> R=0xFFFFFFFF, M=0x5678, status 0x40.
REQ-034 Abort: divide started, port E written at T+10 -> busy=0, R=M=0, no later commit; retrigger at T+5 -> commit exactly 33 cycles after the retrigger.
REQ-035 PAD: MUL_PAD=3 -> R updates at T+17, busy clears after T+20; RESET at T+8 -> all registers 0, IDLE.
